euler_multi_accumulator: RTL and testbench
==========================================

Name: euler_multi_accumulator

Overview:
- Multi-channel signed accumulator for the Euler integration datapath: one running sum per state variable (x_i += h*f_i).
- Each channel has a per-channel load/add operation, wrap or saturate arithmetic, a sticky overflow flag and a step counter.
- A valid/ready input handshake and a one-stage registered output slice allow the block to sit between the multiplier stage and write-back.

Parameters:
- Size, 16, data width in bits, two's complement.
- Channels, 4, number of independent accumulators (>=1).
- ChW, 2, channel index width; must satisfy ceil(log2(Channels)) <= ChW.
- CntW, 16, per-channel step counter width.
- Saturate, 1, 1 = clamp on overflow, 0 = wrap modulo 2^Size.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_async_n  in  1  asynchronous active-low reset.
- clr_all  in  1  synchronous clear of all channels, counters and flags.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept an operation this cycle.
- in_ch  in  ChW  target channel.
- in_load  in  1  1 = acc <= in_data (initial condition), 0 = acc <= acc + in_data.
- in_data  in  Size  operand.
- out_valid  out  1  output slice holds a result.
- out_ready  in  1  consumer accepts the result.
- out_ch  out  ChW  channel of the result.
- out_data  out  Size  updated accumulator value.
- out_ovf  out  1  overflow occurred on this operation.
- ovf_sticky  out  Channels  per-channel sticky overflow; bit i belongs to channel i.
- step_cnt  out  Channels*CntW  packed per-channel add counters; channel i occupies [i*CntW +: CntW].

Behaviour:
- Reset (rst_async_n=0, asynchronous): all accumulators 0, step counters 0, ovf_sticky 0, out_valid 0, out_ch 0, out_data 0, out_ovf 0. Mid-operation reset drops any pending result.
- Handshake: in_ready = !out_valid | out_ready. An operation is accepted when in_valid & in_ready. in_ready depends only on out_valid/out_ready, never on in_valid.
- Accept with in_load=0:
  - sum = acc[in_ch] + in_data, Size-bit.
  - ovf = operand signs equal and sum sign differs.
  - Saturate=1 and ovf: result = 0x7FFF (Size-bit max) if in_data >= 0, else 0x8000 (min).
  - Saturate=0: result = sum (wrapped).
  - step_cnt[in_ch] increments; it wraps at 2^CntW.
- Accept with in_load=1: result = in_data, ovf=0, step_cnt[in_ch] <= 0, ovf_sticky[in_ch] <= 0.
- On accept, in the same edge:
  - acc[in_ch] <= result.
  - ovf_sticky[in_ch] |= ovf (for add).
  - out_valid <= 1, out_ch <= in_ch, out_data <= result, out_ovf <= ovf.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 operation per cycle while out_ready=1.
- Back-to-back operations to the same channel see the updated value; there is no hazard stall (register-array read and write in the same cycle).
- Output slice:
  - If out_valid & !out_ready: hold out_* stable and in_ready=0.
  - If out_valid & out_ready and no new accept: out_valid <= 0.
  - out_* change only on accept.
- in_ch >= Channels: the operation is accepted, no state changes, and the output reports out_data=0, out_ovf=0.
- clr_all=1 (priority over accept):
  - Zero all accumulators, counters and sticky flags; out_valid <= 0.
  - Any input presented that cycle is discarded; in_ready is still driven by the normal rule.

Test Plan:
- Reset, then load ch0 with 0x0100 and add 0x0010 three times, out_ready=1 -> out_data sequence 0x0100, 0x0110, 0x0120, 0x0130 on consecutive cycles; step_cnt ch0 = 3; out_ovf=0 throughout.
- Saturate=1, load ch1 with 0x7FF0, add 0x0020 -> out_data=0x7FFF, out_ovf=1, ovf_sticky[1]=1. A later add of 0xFFFF gives 0x7FFE with out_ovf=0 while sticky stays 1. Loading ch1 clears the sticky bit.
- Saturate=0, load ch2 with 0x8005, add 0xFFF0 -> out_data=0x7FF5, out_ovf=1. Load 0x8000 and add 0x8000 -> 0x0000 with ovf=1. Repeat with Saturate=1 -> 0x8000.
- Backpressure: out_ready=0 with two ops pending -> first result held stable and in_ready=0. Release out_ready -> results delivered in order with no loss or duplication. Interleave ch0/ch3 to confirm channel isolation.
- Assert rst_async_n low mid-stream, between clock edges -> out_valid and all state go to 0 immediately, with no clock edge needed. After release, add 0x0001 to ch0 -> out_data=0x0001.
- clr_all coincident with a valid add to ch3 -> add discarded; next cycle out_valid=0 and all step_cnt/ovf_sticky are 0.

Source files
------------

// File: rtl/euler_multi_accumulator.sv
// rtl/euler_multi_accumulator.sv - multi-channel signed Euler accumulator with wrap/saturate,
// sticky overflow, per-channel step counters and a one-stage registered output slice.
module euler_multi_accumulator #(
  parameter int Size     = 16,
  parameter int Channels = 4,
  parameter int ChW      = 2,
  parameter int CntW     = 16,
  parameter int Saturate = 1
) (
  input  logic                     clk,
  input  logic                     rst_async_n,
  input  logic                     clr_all,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ChW-1:0]           in_ch,
  input  logic                     in_load,
  input  logic [Size-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ChW-1:0]           out_ch,
  output logic [Size-1:0]          out_data,
  output logic                     out_ovf,
  output logic [Channels-1:0]      ovf_sticky,
  output logic [Channels*CntW-1:0] step_cnt
);

  localparam logic [Size-1:0] MaxVal  = {1'b0, {(Size-1){1'b1}}};
  localparam logic [Size-1:0] MinVal  = {1'b1, {(Size-1){1'b0}}};
  localparam logic [ChW:0]    ChLimit = (ChW+1)'(Channels);

  logic [Channels-1:0][Size-1:0] acc_q, acc_d;
  logic [Channels-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [Channels-1:0]           sticky_q, sticky_d;
  logic                          out_valid_q, out_valid_d;
  logic [ChW-1:0]                out_ch_q, out_ch_d;
  logic [Size-1:0]               out_data_q, out_data_d;
  logic                          out_ovf_q, out_ovf_d;

  logic            accept;
  logic            ch_ok;
  logic [Size-1:0] cur;
  logic [Size-1:0] sum;
  logic            add_ovf;
  logic [Size-1:0] result;
  logic            ovf;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign ch_ok    = {1'b0, in_ch} < ChLimit;

  // Operand read from the current register array, so back-to-back ops see the newest value.
  always_comb begin
    cur = '0;
    for (int i = 0; i < Channels; i++) begin
      if (in_ch == ChW'(i)) cur = acc_q[i];
    end
    sum     = cur + in_data;
    add_ovf = (cur[Size-1] == in_data[Size-1]) && (sum[Size-1] != cur[Size-1]);
    if (in_load) begin
      result = in_data;
      ovf    = 1'b0;
    end else if ((Saturate != 0) && add_ovf) begin
      result = in_data[Size-1] ? MinVal : MaxVal;
      ovf    = 1'b1;
    end else begin
      result = sum;
      ovf    = add_ovf;
    end
    if (!ch_ok) begin
      result = '0;
      ovf    = 1'b0;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (clr_all) begin
      acc_d       = '0;
      cnt_d       = '0;
      sticky_d    = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_ch_d    = in_ch;
      out_data_d  = result;
      out_ovf_d   = ovf;
      for (int i = 0; i < Channels; i++) begin
        if (in_ch == ChW'(i)) begin
          acc_d[i] = result;
          if (in_load) begin
            cnt_d[i]    = '0;
            sticky_d[i] = 1'b0;
          end else begin
            cnt_d[i]    = cnt_q[i] + CntW'(1);
            sticky_d[i] = sticky_q[i] | ovf;
          end
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;
  assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_euler_multi_accumulator.sv
// tb/tb_euler_multi_accumulator.sv - scoreboard bench; saturating 4-channel and wrapping 3-channel
// instances share one stimulus stream so ch3 is also an out-of-range channel for the wrapping one.
module tb_euler_multi_accumulator;

  logic        clk = 1'b0;
  logic        rst_async_n, clr_all, in_valid, in_load, out_ready;
  logic [1:0]  in_ch;
  logic [15:0] in_data;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [1:0]  s_out_ch;
  logic [15:0] s_out_data;
  logic [3:0]  s_ovf_sticky;
  logic [63:0] s_step_cnt;

  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [1:0]  w_out_ch;
  logic [15:0] w_out_data;
  logic [2:0]  w_ovf_sticky;
  logic [47:0] w_step_cnt;

  euler_multi_accumulator #(.Size(16), .Channels(4), .ChW(2), .CntW(16), .Saturate(1)) u_sat (
    .clk(clk), .rst_async_n(rst_async_n), .clr_all(clr_all), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_ch(in_ch), .in_load(in_load), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch), .out_data(s_out_data),
    .out_ovf(s_out_ovf), .ovf_sticky(s_ovf_sticky), .step_cnt(s_step_cnt)
  );

  euler_multi_accumulator #(.Size(16), .Channels(3), .ChW(2), .CntW(16), .Saturate(0)) u_wrap (
    .clk(clk), .rst_async_n(rst_async_n), .clr_all(clr_all), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_ch(in_ch), .in_load(in_load), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_ch(w_out_ch), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .ovf_sticky(w_ovf_sticky), .step_cnt(w_step_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t        q_s[$];
  exp_t        q_w[$];
  logic [15:0] m_acc[2][4];
  logic [15:0] m_cnt[2][4];
  logic [3:0]  m_sticky[2];
  bit          mv = 1'b0;
  int          nch[2] = '{4, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        m_acc[d][c] = '0;
        m_cnt[d][c] = '0;
      end
      m_sticky[d] = '0;
    end
    mv = 1'b0;
    q_s.delete();
    q_w.delete();
  endtask

  task automatic model_edge();
    exp_t        e;
    logic [15:0] sum, res;
    logic        o;
    bit          acc_ok;
    if (!rst_async_n) begin
      model_reset();
      return;
    end
    acc_ok = in_valid && (!mv || out_ready);
    if (clr_all) begin
      if (mv && !out_ready) begin
        void'(q_s.pop_back());
        void'(q_w.pop_back());
      end
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin
          m_acc[d][c] = '0;
          m_cnt[d][c] = '0;
        end
        m_sticky[d] = '0;
      end
      mv = 1'b0;
    end else if (acc_ok) begin
      for (int d = 0; d < 2; d++) begin
        e.ch = in_ch; e.data = '0; e.ovf = 1'b0;
        if (int'(in_ch) < nch[d]) begin
          if (in_load) begin
            res = in_data; o = 1'b0;
            m_cnt[d][in_ch] = '0;
            m_sticky[d][in_ch] = 1'b0;
          end else begin
            sum = m_acc[d][in_ch] + in_data;
            o = (m_acc[d][in_ch][15] == in_data[15]) && (sum[15] != in_data[15]);
            res = (d == 0 && o) ? (in_data[15] ? 16'h8000 : 16'h7FFF) : sum;
            m_cnt[d][in_ch] = m_cnt[d][in_ch] + 16'd1;
            m_sticky[d][in_ch] = m_sticky[d][in_ch] | o;
          end
          m_acc[d][in_ch] = res;
          e.data = res; e.ovf = o;
        end
        if (d == 0) q_s.push_back(e); else q_w.push_back(e);
      end
      mv = 1'b1;
    end else if (out_ready) begin
      mv = 1'b0;
    end
  endtask

  function automatic logic [63:0] exp_cnt(int d);
    logic [63:0] r = '0;
    for (int c = 0; c < nch[d]; c++) r[c*16 +: 16] = m_cnt[d][c];
    return r;
  endfunction

  function automatic logic [63:0] exp_sticky(int d);
    logic [63:0] r = '0;
    for (int c = 0; c < nch[d]; c++) r[c] = m_sticky[d][c];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input logic [1:0] ch, input logic ld, input logic [15:0] d);
    in_valid = 1'b1; in_ch = ch; in_load = ld; in_data = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_state();
    chk("s_step_cnt", s_step_cnt, exp_cnt(0));
    chk("w_step_cnt", 64'(w_step_cnt), exp_cnt(1));
    chk("s_sticky", 64'(s_ovf_sticky), exp_sticky(0));
    chk("w_sticky", 64'(w_ovf_sticky), exp_sticky(1));
  endtask

  // Transfer happens at the next rising edge when valid and ready are both high at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    chk("s_in_ready", 64'(s_in_ready), 64'(!mv || out_ready));
    chk("w_in_ready", 64'(w_in_ready), 64'(!mv || out_ready));
    if (s_out_valid && out_ready) begin
      chk("s_result_expected", 64'(q_s.size() > 0), 64'(1));
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("s_result", 64'({s_out_ch, s_out_data, s_out_ovf}), 64'(e));
      end
    end
    if (w_out_valid && out_ready) begin
      chk("w_result_expected", 64'(q_w.size() > 0), 64'(1));
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        chk("w_result", 64'({w_out_ch, w_out_data, w_out_ovf}), 64'(e));
      end
    end
  end

  initial begin
    rst_async_n = 1'b0; clr_all = 1'b0; in_valid = 1'b0; in_load = 1'b0;
    in_ch = '0; in_data = '0; out_ready = 1'b1;
    model_reset();
    tick();
    tick();
    chk("rst_out_valid", 64'(s_out_valid), 64'(0));
    chk("rst_out_fields", 64'({s_out_ch, s_out_data, s_out_ovf}), 64'(0));
    chk("rst_w_out_valid", 64'(w_out_valid), 64'(0));
    chk_state();
    rst_async_n = 1'b1;
    idle();

    op(2'd0, 1'b1, 16'h0100); chk("seq0", 64'(s_out_data), 64'h0100);
    op(2'd0, 1'b0, 16'h0010); chk("seq1", 64'(s_out_data), 64'h0110);
    op(2'd0, 1'b0, 16'h0010); chk("seq2", 64'(s_out_data), 64'h0120);
    op(2'd0, 1'b0, 16'h0010); chk("seq3", 64'(s_out_data), 64'h0130);
    chk("seq3_ovf", 64'(s_out_ovf), 64'(0));
    idle();
    chk("cnt_ch0", 64'(s_step_cnt[15:0]), 64'd3);

    op(2'd1, 1'b1, 16'h7FF0);
    op(2'd1, 1'b0, 16'h0020);
    chk("sat_pos", 64'({s_out_data, s_out_ovf}), 64'({16'h7FFF, 1'b1}));
    chk("wrap_pos", 64'({w_out_data, w_out_ovf}), 64'({16'h8010, 1'b1}));
    idle();
    chk("sticky1_set", 64'(s_ovf_sticky[1]), 64'(1));
    op(2'd1, 1'b0, 16'hFFFF);
    chk("sat_after", 64'({s_out_data, s_out_ovf}), 64'({16'h7FFE, 1'b0}));
    chk("sticky1_hold", 64'(s_ovf_sticky[1]), 64'(1));
    op(2'd1, 1'b1, 16'h0005);
    chk("sticky1_clr", 64'(s_ovf_sticky[1]), 64'(0));

    op(2'd2, 1'b1, 16'h8005);
    op(2'd2, 1'b0, 16'hFFF0);
    chk("wrap_neg", 64'({w_out_data, w_out_ovf}), 64'({16'h7FF5, 1'b1}));
    chk("sat_neg", 64'({s_out_data, s_out_ovf}), 64'({16'h8000, 1'b1}));
    op(2'd2, 1'b1, 16'h8000);
    op(2'd2, 1'b0, 16'h8000);
    chk("wrap_min", 64'({w_out_data, w_out_ovf}), 64'({16'h0000, 1'b1}));
    chk("sat_min", 64'({s_out_data, s_out_ovf}), 64'({16'h8000, 1'b1}));
    idle();
    chk_state();

    out_ready = 1'b0;
    op(2'd0, 1'b0, 16'h0001);
    op(2'd3, 1'b1, 16'h0033);
    chk("bp_hold0", 64'({s_out_valid, s_out_ch, s_out_data}), 64'({1'b1, 2'd0, 16'h0131}));
    chk("bp_ready0", 64'(s_in_ready), 64'(0));
    tick();
    chk("bp_hold1", 64'({s_out_valid, s_out_ch, s_out_data}), 64'({1'b1, 2'd0, 16'h0131}));
    out_ready = 1'b1;
    tick();
    chk("bp_next", 64'({s_out_ch, s_out_data}), 64'({2'd3, 16'h0033}));
    chk("oor_w", 64'({w_out_ch, w_out_data, w_out_ovf}), 64'({2'd3, 16'h0000, 1'b0}));
    for (int k = 0; k < 24; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      op((k % 2) ? 2'd3 : 2'd0, 1'b0, 16'($urandom_range(0, 15)));
    end
    out_ready = 1'b1;
    idle();
    idle();
    chk_state();

    out_ready = 1'b0;
    op(2'd0, 1'b0, 16'h0005);
    in_valid = 1'b0;
    #2;
    rst_async_n = 1'b0;
    model_reset();
    #1;
    chk("arst_out", 64'({s_out_valid, s_out_ch, s_out_data, s_out_ovf}), 64'(0));
    chk("arst_w_out", 64'(w_out_valid), 64'(0));
    chk_state();
    tick();
    #2;
    rst_async_n = 1'b1;
    out_ready = 1'b1;
    op(2'd0, 1'b0, 16'h0001);
    chk("post_rst", 64'({s_out_valid, s_out_data}), 64'({1'b1, 16'h0001}));

    op(2'd1, 1'b1, 16'h7FFF);
    op(2'd1, 1'b0, 16'h0001);
    op(2'd3, 1'b1, 16'h0010);
    op(2'd3, 1'b0, 16'h0001);
    clr_all = 1'b1;
    op(2'd3, 1'b0, 16'h0007);
    clr_all = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 64'({s_out_valid, w_out_valid}), 64'(0));
    chk("clr_cnt", s_step_cnt, 64'(0));
    chk("clr_sticky", 64'(s_ovf_sticky), 64'(0));
    chk_state();
    idle();
    idle();
    chk("s_queue_empty", 64'(q_s.size()), 64'(0));
    chk("w_queue_empty", 64'(q_w.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
